pixel_frame_buffer: RTL
=======================

// Module: pixel_frame_buffer
// PURPOSE
//  Double-buffered pixel store feeding the HUB75 panel control stage. Game/drawing logic writes
//  single pixels into the back bank; the control stage reads the front bank as the
//  {R0,G0,B0,R1,G1,B1} pair for (row A-D, column). A swap only occurs on the control's
//  frame-end strobe, so a frame is never torn. A sweep clear zeroes the back bank.
// PARAMETERS
//  WIDTH   64  panel columns; XW = $clog2(WIDTH) (localparam)
//  HEIGHT  32  panel rows, even; scan rows = HEIGHT/2; YW = $clog2(HEIGHT), RW = YW-1 (localparams)
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst        in   1   synchronous reset, active-high
//  wr_en      in   1   pixel write strobe (back bank)
//  wr_x       in   XW  write column
//  wr_y       in   YW  write row 0..HEIGHT-1
//  wr_rgb     in   3   {R,G,B} written
//  clear_req  in   1   pulse: start zeroing back bank
//  swap_req   in   1   pulse: request front/back swap at next frame end
//  frame_end  in   1   1-cycle strobe from control after last scan row latched
//  rd_en      in   1   read request from control
//  rd_row     in   RW  scan row (A-D address)
//  rd_col     in   XW  column being shifted
//  rd_data    out  6   {R0,G0,B0,R1,G1,B1}
//  rd_valid   out  1   rd_data updated this cycle
//  busy       out  1   clear in progress; writes dropped
//  swap_done  out  1   1-cycle pulse on the cycle front_sel toggles
//  front_sel  out  1   bank currently displayed
// BEHAVIOUR
//  Reset: rd_data=0, rd_valid=0, busy=0, swap_done=0, front_sel=0, swap_pending=0, FSM=IDLE.
//   Memory not reset; clear_req + swap is the init path. rst mid-clear aborts clear; memory stays partial.
//  Storage: per bank, UPPER and LOWER arrays of WIDTH*HEIGHT/2 x 3 bits, addr = row*WIDTH+col.
//   wr_y < HEIGHT/2 -> UPPER[wr_y]; else LOWER[wr_y-HEIGHT/2]. Single write, no read-modify-write.
//  Write: accepted iff wr_en & !busy & wr_x<WIDTH & wr_y<HEIGHT; goes to bank ~front_sel.
//   Otherwise silently dropped (no error flag).
//  Read: rd_en at cycle t -> rd_data = {UPPER[f][a], LOWER[f][a]} (f=front_sel at t), rd_valid=1 at t+1.
//   rd_en=0 -> rd_valid=0 next cycle, rd_data holds. Fixed 1-cycle latency, back-to-back every cycle.
//   Reads always served, including during CLEAR.
//  Swap: swap_req sets swap_pending (idempotent). Swap when frame_end & (swap_pending|swap_req) & FSM=IDLE:
//   front_sel toggles, swap_pending clears, swap_done=1 that cycle+1 (registered). swap_req coincident
//   with frame_end swaps on that frame_end. frame_end during CLEAR: no swap, pending kept.
//  Clear FSM: IDLE --clear_req--> CLEAR (busy=1 next cycle). CLEAR writes 0 to UPPER and LOWER of back
//   bank at addr cnt, cnt 0..WIDTH*HEIGHT/2-1, one addr/cycle; on last addr -> IDLE, busy=0 next cycle.
//   busy high exactly WIDTH*HEIGHT/2 cycles. clear_req in CLEAR ignored. Back bank fixed during CLEAR
//   (swap blocked). clear_req and wr_en same cycle in IDLE: write ignored, clear starts.
//  Widths: address math at width RW+XW (UPPER/LOWER) so no overflow; cnt is RW+XW bits, no wrap.
// TESTING
//  1 rst; clear_req; wait !busy; swap_req; frame_end; clear_req; wait !busy -> both banks 0;
//    rd_en row0 col0 -> rd_data=6'b000000, rd_valid next cycle only.
//  2 write (x=3,y=2,rgb=101),(x=3,y=18,rgb=011); swap_req; frame_end -> swap_done pulse, front_sel flips;
//    rd row2 col3 -> 6'b101011.
//  3 after writes, swap_req but no frame_end for 100 cycles -> front_sel stable, reads return old data.
//  4 clear_req -> busy high exactly 1024 cycles (64x32/2); wr_en during busy dropped (reads 0 after swap);
//    frame_end during busy with swap_pending -> no swap; next frame_end after busy=0 swaps.
//  5 swap_req and frame_end same cycle, FSM IDLE -> front_sel toggles, swap_done next cycle.
//  6 rst asserted at clear cycle 500 -> next cycle busy=0, front_sel=0, rd_valid=0, swap_pending=0.

Source files
------------

// File: rtl/pixel_frame_buffer.sv
// pixel_frame_buffer: double-buffered pixel store for the HUB75 panel control stage.
// Ports: pixel write port (wr_*), back-bank clear (clear_req/busy), frame-synchronous
// swap (swap_req/frame_end/swap_done/front_sel) and a 1-cycle-latency read of the
// upper/lower half pixel pair (rd_en/rd_row/rd_col -> rd_data/rd_valid).
module pixel_frame_buffer #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(WIDTH)-1:0]    wr_x,
  input  logic [$clog2(HEIGHT)-1:0]   wr_y,
  input  logic [2:0]                  wr_rgb,
  input  logic                        clear_req,
  input  logic                        swap_req,
  input  logic                        frame_end,
  input  logic                        rd_en,
  input  logic [$clog2(HEIGHT)-2:0]   rd_row,
  input  logic [$clog2(WIDTH)-1:0]    rd_col,
  output logic [5:0]                  rd_data,
  output logic                        rd_valid,
  output logic                        busy,
  output logic                        swap_done,
  output logic                        front_sel
);

  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int RW    = YW - 1;
  localparam int AW    = RW + XW;
  localparam int HALF  = HEIGHT / 2;
  localparam int DEPTH = WIDTH * HALF;

  localparam logic [XW:0]   X_LIM  = (XW+1)'(WIDTH);
  localparam logic [YW:0]   Y_LIM  = (YW+1)'(HEIGHT);
  localparam logic [YW:0]   Y_HALF = (YW+1)'(HALF);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] cnt;
  logic          swap_pending;

  // Bank index first, then row*WIDTH+col within the half panel.
  logic [2:0] upper [2][DEPTH];
  logic [2:0] lower [2][DEPTH];

  logic          back;
  logic          in_range;
  logic          wr_low;
  logic          wr_ok;
  logic          do_swap;
  logic [RW-1:0] wr_row;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign back     = ~front_sel;
  assign busy     = (state == CLEAR);
  assign in_range = ({1'b0, wr_x} < X_LIM) &&
                    ({1'b0, wr_y} < Y_LIM);
  assign wr_low   = ({1'b0, wr_y} >= Y_HALF);
  assign wr_row   = wr_low ? RW'(wr_y - YW'(HALF))
                           : RW'(wr_y);
  assign wr_addr  = AW'(wr_row) * AW'(WIDTH)
                  + AW'(wr_x);
  assign rd_addr  = AW'(rd_row) * AW'(WIDTH)
                  + AW'(rd_col);

  // A clear request wins over a write issued in the same cycle.
  assign wr_ok    = wr_en && (state == IDLE)
                 && !clear_req && in_range;

  // Swapping is held off while the back bank is being cleared.
  assign do_swap  = frame_end && (state == IDLE)
                 && (swap_pending || swap_req);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (clear_req) state_n = CLEAR;
      CLEAR: if (cnt == LAST) state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
      swap_done    <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      state <= state_n;
      if ((state == CLEAR) && (state_n == CLEAR))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      swap_done <= do_swap;
      if (do_swap) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= {upper[front_sel][rd_addr],
                    lower[front_sel][rd_addr]};
    end
  end

  // Storage is deliberately not reset; a clear plus swap initialises it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        upper[back][cnt] <= 3'b000;
        lower[back][cnt] <= 3'b000;
      end else if (wr_ok) begin
        if (wr_low)
          lower[back][wr_addr] <= wr_rgb;
        else
          upper[back][wr_addr] <= wr_rgb;
      end
    end
  end

endmodule
